rs_alu_bank: RTL

- Bank of ALU reservation-station entries directly downstream of the instruction queue.
- Each issue from the IQ writes one entry: destination ROB tag, ALU op, and two operands, each given as a value or as a pending ROB tag.
- Entries snoop the common data buses (CDB) to pick up pending operands.
- When both operands are present, the entry moves into a registered dispatch slot that feeds one ALU through a valid/ready handshake.

---
 rtl/rs_alu_bank.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/rs_alu_bank.sv
// ALU reservation-station bank: entries capture operands from the IQ and the CDBs,
// and the lowest-index ready entry moves into a registered valid/ready dispatch slot.
module rs_alu_bank #(
    parameter int  NUM_RS  = 10,
    parameter int  NUM_CDB = 5,
    parameter int  ROB_W   = 5,
    parameter int  DATA_W  = 32,
    localparam int SEL_W   = $clog2(NUM_RS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       load_rs,
    input  logic [SEL_W-1:0]           rs_sel,
    input  logic [ROB_W-1:0]           dest_rob,
    input  logic [2:0]                 alu_ops,
    input  logic [ROB_W-1:0]           src1_rob,
    input  logic [ROB_W-1:0]           src2_rob,
    input  logic [DATA_W-1:0]          src1_value,
    input  logic [DATA_W-1:0]          src2_value,
    input  logic                       src1_valid,
    input  logic                       src2_valid,
    input  logic [NUM_CDB-1:0]         cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0]   cdb_rob,
    input  logic [NUM_CDB*DATA_W-1:0]  cdb_value,
    output logic [NUM_RS-1:0]          rs_busy,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [ROB_W-1:0]           issue_dest_rob,
    output logic [2:0]                 issue_alu_ops,
    output logic [DATA_W-1:0]          issue_a,
    output logic [DATA_W-1:0]          issue_b
);

    // Returns {hit, value}; iterating downward lets the lowest matching bus win.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [ROB_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*ROB_W-1:0]  robs,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int b = NUM_CDB - 1; b >= 0; b--) begin
            res = (vld[b] && (robs[b*ROB_W +: ROB_W] == tag)) ?
                  {1'b1, vals[b*DATA_W +: DATA_W]} : res;
        end
        return res;
    endfunction

    logic [NUM_RS-1:0] busy_q, busy_d, v1_q, v1_d, v2_q, v2_d;
    logic [ROB_W-1:0]  dest_q [NUM_RS];
    logic [ROB_W-1:0]  dest_d [NUM_RS];
    logic [2:0]        op_q   [NUM_RS];
    logic [2:0]        op_d   [NUM_RS];
    logic [ROB_W-1:0]  t1_q   [NUM_RS];
    logic [ROB_W-1:0]  t1_d   [NUM_RS];
    logic [ROB_W-1:0]  t2_q   [NUM_RS];
    logic [ROB_W-1:0]  t2_d   [NUM_RS];
    logic [DATA_W-1:0] val1_q [NUM_RS];
    logic [DATA_W-1:0] val1_d [NUM_RS];
    logic [DATA_W-1:0] val2_q [NUM_RS];
    logic [DATA_W-1:0] val2_d [NUM_RS];

    logic              issue_valid_q, issue_valid_d;
    logic [ROB_W-1:0]  issue_dest_q, issue_dest_d;
    logic [2:0]        issue_op_q, issue_op_d;
    logic [DATA_W-1:0] issue_a_q, issue_a_d, issue_b_q, issue_b_d;

    logic [NUM_RS-1:0] ready_s, freed_s, load_hit_s, conflict_s;
    logic [SEL_W-1:0]  sel_s;
    logic              any_ready_s, slot_load_s, load_conflict_s;
    logic [DATA_W:0]   fwd1_s, fwd2_s;
    logic [DATA_W:0]   snp1_s [NUM_RS];
    logic [DATA_W:0]   snp2_s [NUM_RS];

    // CDB matches for the incoming operands and for every stored pending tag.
    always_comb begin
        fwd1_s = cdb_lookup(src1_rob, cdb_valid, cdb_rob, cdb_value);
        fwd2_s = cdb_lookup(src2_rob, cdb_valid, cdb_rob, cdb_value);
        for (int i = 0; i < NUM_RS; i++) begin
            snp1_s[i] = cdb_lookup(t1_q[i], cdb_valid, cdb_rob, cdb_value);
            snp2_s[i] = cdb_lookup(t2_q[i], cdb_valid, cdb_rob, cdb_value);
        end
    end

    // Oldest-state readiness, lowest-index selection, and which entry is freed/loaded.
    always_comb begin
        sel_s       = '0;
        any_ready_s = 1'b0;
        ready_s     = busy_q & v1_q & v2_q;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            sel_s       = ready_s[i] ? SEL_W'(i) : sel_s;
            any_ready_s = any_ready_s | ready_s[i];
        end
        slot_load_s = any_ready_s && (!issue_valid_q || issue_ready);
        for (int i = 0; i < NUM_RS; i++) begin
            freed_s[i]    = slot_load_s && (sel_s == SEL_W'(i));
            load_hit_s[i] = load_rs && (rs_sel == SEL_W'(i)) && (!busy_q[i] || freed_s[i]);
            conflict_s[i] = load_rs && !flush && (rs_sel == SEL_W'(i)) && busy_q[i] && !freed_s[i];
        end
        load_conflict_s = |conflict_s;
    end

    // Entry next state: flush, then load, then dispatch-free, then snoop.
    always_comb begin
        busy_d = busy_q;
        v1_d   = v1_q;
        v2_d   = v2_q;
        dest_d = dest_q;
        op_d   = op_q;
        t1_d   = t1_q;
        t2_d   = t2_q;
        val1_d = val1_q;
        val2_d = val2_q;
        for (int i = 0; i < NUM_RS; i++) begin
            if (flush) begin
                busy_d[i] = 1'b0;
                v1_d[i]   = 1'b0;
                v2_d[i]   = 1'b0;
            end else if (load_hit_s[i]) begin
                busy_d[i] = 1'b1;
                dest_d[i] = dest_rob;
                op_d[i]   = alu_ops;
                t1_d[i]   = src1_rob;
                t2_d[i]   = src2_rob;
                v1_d[i]   = src1_valid | fwd1_s[DATA_W];
                v2_d[i]   = src2_valid | fwd2_s[DATA_W];
                val1_d[i] = src1_valid ? src1_value : fwd1_s[DATA_W-1:0];
                val2_d[i] = src2_valid ? src2_value : fwd2_s[DATA_W-1:0];
            end else if (freed_s[i]) begin
                busy_d[i] = 1'b0;
            end else if (busy_q[i]) begin
                v1_d[i]   = v1_q[i] | snp1_s[i][DATA_W];
                v2_d[i]   = v2_q[i] | snp2_s[i][DATA_W];
                val1_d[i] = v1_q[i] ? val1_q[i] : snp1_s[i][DATA_W-1:0];
                val2_d[i] = v2_q[i] ? val2_q[i] : snp2_s[i][DATA_W-1:0];
            end else begin
                busy_d[i] = 1'b0;
            end
        end
    end

    // Dispatch slot: refill on empty or completed transfer, otherwise hold.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_dest_d  = issue_dest_q;
        issue_op_d    = issue_op_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        if (flush) begin
            issue_valid_d = 1'b0;
            issue_dest_d  = '0;
            issue_op_d    = 3'd0;
            issue_a_d     = '0;
            issue_b_d     = '0;
        end else if (slot_load_s) begin
            issue_valid_d = 1'b1;
            issue_dest_d  = dest_q[sel_s];
            issue_op_d    = op_q[sel_s];
            issue_a_d     = val1_q[sel_s];
            issue_b_d     = val2_q[sel_s];
        end else if (issue_ready) begin
            issue_valid_d = 1'b0;
        end else begin
            issue_valid_d = issue_valid_q;
        end
    end

    // Control state and dispatch slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            issue_valid_q <= 1'b0;
            issue_dest_q  <= '0;
            issue_op_q    <= 3'd0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
        end else begin
            busy_q        <= busy_d;
            issue_valid_q <= issue_valid_d;
            issue_dest_q  <= issue_dest_d;
            issue_op_q    <= issue_op_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
        end
    end

    // Entry payload; only meaningful while busy, so no reset is needed.
    always_ff @(posedge clk) begin
        v1_q   <= v1_d;
        v2_q   <= v2_d;
        dest_q <= dest_d;
        op_q   <= op_d;
        t1_q   <= t1_d;
        t2_q   <= t2_d;
        val1_q <= val1_d;
        val2_q <= val2_d;
    end

    assign rs_busy        = busy_q;
    assign issue_valid    = issue_valid_q;
    assign issue_dest_rob = issue_dest_q;
    assign issue_alu_ops  = issue_op_q;
    assign issue_a        = issue_a_q;
    assign issue_b        = issue_b_q;

    rs_alu_bank_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .load_conflict (load_conflict_s)
    );

endmodule

// Protocol checker: the IQ must never load an entry that stays busy this cycle.
module rs_alu_bank_chk (
    input logic clk,
    input logic rst,
    input logic load_conflict
);
    a_no_load_to_busy: assert property (@(posedge clk) disable iff (rst) !load_conflict);
endmodule
